// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the multi-ported register file slice.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   clog2()             : elaboration-time ceiling log2, used to derive AW
//   reg_idx_t           : register index type for the default configuration
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Smallest r with (1 << r) >= n; n = 1 yields 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int AW_DEF = clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/rf_bypass_mux.sv
// -----------------------------------------------------------------------------
// rf_bypass_mux
// One read port of the register file. Chooses between the stored array value
// and the winning same-cycle write (highest enabled write port index), and
// derives the busy bit seen by the reader.
// Ports:
//   rst       in   async reset level; forces zero outputs while high
//   rd_addr   in   AW        register being read
//   arr_data  in   XLEN      stored value of rd_addr
//   arr_busy  in   1         stored busy bit of rd_addr
//   wr_en     in   NWR       write strobes
//   wr_addr   in   NWR*AW    write addresses
//   wr_data   in   NWR*XLEN  write data
//   wr_clr    in   NWR       busy-clear qualifiers (only with wr_en)
//   rd_data   out  XLEN      data returned to the reader
//   rd_busy   out  1         busy bit returned to the reader
// -----------------------------------------------------------------------------
module rf_bypass_mux #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                rst,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     arr_data,
    input  logic                arr_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      wr_clr,
    output logic [XLEN-1:0]     rd_data,
    output logic                rd_busy
);

    logic            w_hit;
    logic            w_hit_clr;
    logic [XLEN-1:0] w_hit_data;

    // Scan ascending so the highest-index matching port overwrites earlier hits.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        w_hit      = 1'b0;
        w_hit_clr  = 1'b0;
        w_hit_data = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && (wr_addr[i*AW +: AW] == rd_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = wr_data[i*XLEN +: XLEN];
                // Any clearing port on this address clears, not just the winner.
                if (wr_clr[i]) w_hit_clr = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = arr_data;
        rd_busy = arr_busy;
        if ((BYPASS != 0) && w_hit) begin
            rd_data = w_hit_data;
            if (w_hit_clr) rd_busy = 1'b0;
        end
        // r0 is hardwired zero / never busy; reset hides everything.
        if (rst || (rd_addr == '0)) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
// Multi-ported general-purpose register file with write bypass and a
// per-register busy scoreboard. r0 reads as zero and is never busy.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   rd_addr   in   NRD*AW    read addresses, port k at [k*AW +: AW]
//   rd_data   out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
//   rd_busy   out  NRD       busy bit of each read address
//   wr_en     in   NWR       write strobes (higher index has priority)
//   wr_addr   in   NWR*AW    write addresses
//   wr_data   in   NWR*XLEN  write data
//   wr_clr    in   NWR       with wr_en, also clear busy of wr_addr
//   rsv_en    in   1         reserve (set busy) rsv_addr at next edge
//   rsv_addr  in   AW        register to reserve
//   busy_cnt  out  AW+1      registered popcount of busy bits
// -----------------------------------------------------------------------------
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREG   = NREG_DEF,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      wr_clr,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_busy_cnt;

    logic [NREG-1:0] w_we;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_rsv;
    logic [NREG-1:0] w_busy_nxt;
    logic [XLEN-1:0] w_wdata [NREG];
    logic [AW:0]     w_cnt_nxt;

    // Per-register write decode. Index 0 is never matched, so r0 stays zero.
    always_comb begin
        w_we  = '0;
        w_clr = '0;
        w_rsv = '0;
        for (int r = 0; r < NREG; r++) w_wdata[r] = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && (wr_addr[i*AW +: AW] == AW'(r))) begin
                    w_we[r]    = 1'b1;
                    w_wdata[r] = wr_data[i*XLEN +: XLEN];
                    if (wr_clr[i]) w_clr[r] = 1'b1;
                end
            end
        end
        if (rsv_en && (rsv_addr != '0)) w_rsv[rsv_addr] = 1'b1;
        // Set after clear: a same-edge reserve beats a clear.
        w_busy_nxt    = (r_busy & ~w_clr) | w_rsv;
        w_busy_nxt[0] = 1'b0;
        w_cnt_nxt = '0;
        for (int r = 0; r < NREG; r++) w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[r]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset because reads after reset must return
            // zero; a plain storage RAM would normally be left unreset.
            for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            for (int r = 0; r < NREG; r++) begin
                if (w_we[r]) r_regs[r] <= w_wdata[r];
            end
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign busy_cnt = r_busy_cnt;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr = rd_addr[k*AW +: AW];

        rf_bypass_mux #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_mux (
            .rst      (rst),
            .rd_addr  (w_addr),
            .arr_data (r_regs[w_addr]),
            .arr_busy (r_busy[w_addr]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .wr_clr   (wr_clr),
            .rd_data  (rd_data[k*XLEN +: XLEN]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Directed bench for regfile_mp_sb. Two instances share all inputs: dut uses
// write bypass, dut_nb does not. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;

    logic [NRD*XLEN-1:0] rd_data_b,  rd_data_n;
    logic [NRD-1:0]      rd_busy_b,  rd_busy_n;
    logic [AW:0]         busy_cnt_b, busy_cnt_n;

    int n_checks;
    int n_errors;

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_b)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en  = '0;
        wr_clr = '0;
        rsv_en = 1'b0;
    endtask

    // Advance one edge; inputs may be changed right after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input int a, input logic [XLEN-1:0] d, input logic c);
        wr_en[p]             = 1'b1;
        wr_addr[p*AW +: AW]  = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
        wr_clr[p]            = c;
    endtask

    task automatic rsv(input int a);
        rsv_en   = 1'b1;
        rsv_addr = AW'(a);
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_addr = '0;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_cnt", 64'(busy_cnt_b), 64'd0);
        rd(0, 5); rd(1, 31); #1;
        check("reset_rd_r5", 64'(rd_data_b[0 +: XLEN]), 64'd0);

        // r0: write and reserve are both dropped.
        wr(0, 0, 32'hFFFF_FFFF, 1'b0); rsv(0); rd(0, 0); #1;
        check("r0_bypass_data", 64'(rd_data_b[0 +: XLEN]), 64'd0);
        check("r0_bypass_busy", 64'(rd_busy_b[0]), 64'd0);
        step(); idle(); #1;
        check("r0_data", 64'(rd_data_b[0 +: XLEN]), 64'd0);
        check("r0_cnt", 64'(busy_cnt_b), 64'd0);

        // Same-edge write priority: port 1 wins.
        wr(0, 3, 32'h11, 1'b0); wr(1, 3, 32'h22, 1'b0); rd(0, 3); rd(1, 3); #1;
        check("prio_bypass", 64'(rd_data_b[0 +: XLEN]), 64'h22);
        check("prio_nobypass_pre", 64'(rd_data_n[XLEN +: XLEN]), 64'h0);
        step(); idle(); #1;
        check("prio_stored", 64'(rd_data_b[XLEN +: XLEN]), 64'h22);
        check("prio_stored_nb", 64'(rd_data_n[0 +: XLEN]), 64'h22);

        // Bypass off: old value visible until the edge.
        wr(0, 7, 32'h44, 1'b0); step(); idle();
        wr(1, 7, 32'h55, 1'b0); rd(0, 7); #1;
        check("nb_same_cycle", 64'(rd_data_n[0 +: XLEN]), 64'h44);
        check("b_same_cycle", 64'(rd_data_b[0 +: XLEN]), 64'h55);
        step(); idle(); #1;
        check("nb_next_cycle", 64'(rd_data_n[0 +: XLEN]), 64'h55);

        // Scoreboard basics on r9.
        rsv(9); step(); idle(); rd(0, 9); #1;
        check("sb_rsv_cnt", 64'(busy_cnt_b), 64'd1);
        check("sb_rsv_busy", 64'(rd_busy_b[0]), 64'd1);
        wr(1, 9, 32'h99, 1'b1); #1;
        check("sb_clr_bypass_busy", 64'(rd_busy_b[0]), 64'd0);
        check("sb_clr_nb_busy", 64'(rd_busy_n[0]), 64'd1);
        step(); idle(); #1;
        check("sb_clr_busy", 64'(rd_busy_n[0]), 64'd0);
        check("sb_clr_cnt", 64'(busy_cnt_n), 64'd0);
        rsv(9); wr(0, 9, 32'h98, 1'b1); step(); idle(); #1;
        check("sb_rsv_beats_clr", 64'(rd_busy_b[0]), 64'd1);
        check("sb_rsv_beats_clr_cnt", 64'(busy_cnt_b), 64'd1);
        wr_clr = 2'b11; wr_addr = {AW'(9), AW'(9)}; step(); idle(); #1;
        check("sb_clr_without_en", 64'(busy_cnt_b), 64'd1);
        // Low port clears, high port supplies the data.
        wr(0, 9, 32'h01, 1'b1); wr(1, 9, 32'hAB, 1'b0); step(); idle(); #1;
        check("sb_lowport_clr_cnt", 64'(busy_cnt_b), 64'd0);
        check("sb_highport_data", 64'(rd_data_b[0 +: XLEN]), 64'hAB);

        // Fill the scoreboard one register per cycle.
        for (int r = 1; r < NREG; r++) begin
            rsv(r); step();
        end
        idle(); rd(0, 1); rd(1, 31); #1;
        check("fill_cnt", 64'(busy_cnt_b), 64'd31);
        check("fill_busy", 64'(rd_busy_b), 64'b11);
        rsv(5); step(); idle(); #1;
        check("fill_rerserve_cnt", 64'(busy_cnt_b), 64'd31);
        for (int r = 1; r < NREG; r += 2) begin
            wr(0, r, 32'(r), 1'b1);
            if (r + 1 < NREG) wr(1, r + 1, 32'(r + 1), 1'b1);
            else wr_en[1] = 1'b0;
            step();
        end
        idle(); #1;
        check("drain_cnt", 64'(busy_cnt_b), 64'd0);
        check("drain_busy", 64'(rd_busy_b), 64'b00);

        // Reset mid-operation: pending write to r6 is lost.
        wr(0, 5, 32'hDEAD, 1'b0); rsv(12); step(); idle();
        rd(0, 5); rd(1, 6); #1;
        check("pre_rst_r5", 64'(rd_data_b[0 +: XLEN]), 64'hDEAD);
        check("pre_rst_cnt", 64'(busy_cnt_b), 64'd1);
        wr(1, 6, 32'hBEEF, 1'b0); rd(1, 12);
        rst = 1'b1; #1;
        check("rst_r5", 64'(rd_data_b[0 +: XLEN]), 64'd0);
        check("rst_busy", 64'(rd_busy_b), 64'b00);
        check("rst_cnt", 64'(busy_cnt_b), 64'd0);
        step(); idle(); rst = 1'b0; rd(1, 6); #1;
        check("rst_lost_write", 64'(rd_data_b[XLEN +: XLEN]), 64'd0);
        check("rst_r5_after", 64'(rd_data_n[0 +: XLEN]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
